aes_iter_engine: RTL

AES_ITER_ENGINE -- requirements
Module: aes_iter_engine

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_round.sv | 49 ++++
 rtl/aes_iter_engine.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count constants, engine state encoding and
// the byte-level primitives (S-box, inverse S-box, GF(2^8) arithmetic).
package aes_pkg;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Byte x of each table sits at bits [8*(255-x) +: 8] (entry 0 at the MSBs).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplier is at most 4 bits wide: MixColumns needs 2/3, the inverse 9/11/13/14.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc ^= p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round, forward or inverse; 'last' drops the
// (Inv)MixColumns step for the final round.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         decrypt,
    input  logic         last,
    output logic [127:0] result
);

    // Byte index 4*c+r is row r of column c; byte 0 is the state MSB.
    logic [7:0] s_in    [16];
    logic [7:0] k_in    [16];
    logic [7:0] enc_sr  [16];
    logic [7:0] enc_mc  [16];
    logic [7:0] dec_ark [16];
    logic [7:0] dec_imc [16];

    // NOTE: every variable written here is fully assigned on each evaluation,
    // so no latch can be inferred; partial assignment would create one.
    always_comb begin
        result = '0;
        for (int i = 0; i < 16; i++) begin
            s_in[i] = state[127-8*i -: 8];
            k_in[i] = round_key[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                enc_sr[4*c+r]  = sbox(s_in[4*((c+r)%4)+r]);
                dec_ark[4*c+r] = inv_sbox(s_in[4*((c+4-r)%4)+r]) ^ k_in[4*c+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                enc_mc[4*c+r]  = gmul(enc_sr[4*c+r], 4'd2) ^ gmul(enc_sr[4*c+(r+1)%4], 4'd3)
                               ^ enc_sr[4*c+(r+2)%4] ^ enc_sr[4*c+(r+3)%4];
                dec_imc[4*c+r] = gmul(dec_ark[4*c+r], 4'd14) ^ gmul(dec_ark[4*c+(r+1)%4], 4'd11)
                               ^ gmul(dec_ark[4*c+(r+2)%4], 4'd13) ^ gmul(dec_ark[4*c+(r+3)%4], 4'd9);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (decrypt) result[127-8*i -: 8] = last ? dec_ark[i] : dec_imc[i];
            else         result[127-8*i -: 8] = (last ? enc_sr[i] : enc_mc[i]) ^ k_in[i];
        end
    end

endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES engine: one round per clock over an externally expanded key,
// with a valid/ready handshake on both the input and the result side.
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter int MAX_NR     = 14,
    parameter bit ENABLE_DEC = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [128*(MAX_NR+1)-1:0] expanded_key,
    input  logic [3:0]                NR,
    input  logic                      i_decrypt,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [127:0]              i_data,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [127:0]              o_data,
    output logic                      o_err
);

    localparam int KW = 128*(MAX_NR+1);

    state_e       state_q, state_d;
    logic [3:0]   nr_q, nr_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         dec_q, dec_d;
    logic         err_q, err_d;
    logic [127:0] data_q, data_d;

    logic [127:0] rk [MAX_NR+1];
    logic [127:0] rk_run, rk_load, round_out;
    logic [3:0]   run_idx, load_idx;
    logic         accept, bad_req, last_round;

    for (genvar k = 0; k <= MAX_NR; k++) begin : g_rk
        assign rk[k] = expanded_key[KW-1-128*k -: 128];
    end

    assign i_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & o_ready);
    assign o_valid    = (state_q == ST_DONE);
    assign o_data     = data_q;
    assign o_err      = err_q;
    assign accept     = i_valid & i_ready;
    assign last_round = (rnd_q == nr_q);
    assign run_idx    = dec_q ? (nr_q - rnd_q) : rnd_q;
    assign load_idx   = i_decrypt ? NR : 4'd0;
    assign bad_req    = !((NR == NR_128) || (NR == NR_192) || (NR == NR_256))
                      || (int'(NR) > MAX_NR) || (i_decrypt && !ENABLE_DEC);

    // Out-of-range indices (only reachable for rejected requests) read as zero.
    always_comb begin
        rk_run  = '0;
        rk_load = '0;
        for (int k = 0; k <= MAX_NR; k++) begin
            if (run_idx == 4'(k))  rk_run  = rk[k];
            if (load_idx == 4'(k)) rk_load = rk[k];
        end
    end

    aes_round u_round (
        .state    (data_q),
        .round_key(rk_run),
        .decrypt  (dec_q & ENABLE_DEC),
        .last     (last_round),
        .result   (round_out)
    );

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                if (err_q) begin
                    data_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    data_d = round_out;
                    if (last_round) state_d = ST_DONE;
                    else            rnd_d   = rnd_q + 4'd1;
                end
            end
            ST_DONE: if (o_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // An accept in DONE coincides with the result handshake and overrides it.
        if (accept) begin
            state_d = ST_RUN;
            nr_d    = NR;
            dec_d   = i_decrypt;
            rnd_d   = 4'd1;
            err_d   = bad_req;
            data_d  = bad_req ? '0 : (i_data ^ rk_load);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            nr_q    <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

endmodule
